// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: ALU function codes, MIPS
// opcode/funct values, FSM encoding and the decoder result bundle.
package alu_pkg;

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_NOR = 5'b00011;
  localparam logic [4:0] ALU_MUL = 5'b00100;
  localparam logic [4:0] ALU_SLL = 5'b00101;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;
  localparam logic [4:0] ALU_SRA = 5'b01000;
  localparam logic [4:0] ALU_XOR = 5'b01011;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_MUL   = 6'h1C;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_MUL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0]  funct;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        trap_cap;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational MIPS instruction decode into ALU function code and operands,
// flagging trap-capable (signed add/sub/addi) and unsupported encodings.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [15:0] imm,
  input  logic [4:0]  shamt,
  output dec_t        dec
);

  logic [31:0] imm_sx, imm_zx;
  assign imm_sx = {{16{imm[15]}}, imm};
  assign imm_zx = {16'b0, imm};

  always_comb begin
    dec          = '0;
    dec.data1    = rs_data;
    dec.data2    = rt_data;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin dec.funct = ALU_ADD; dec.trap_cap = 1'b1; end
          FN_ADDU: dec.funct = ALU_ADD;
          FN_SUB:  begin dec.funct = ALU_SUB; dec.trap_cap = 1'b1; end
          FN_SUBU: dec.funct = ALU_SUB;
          FN_AND:  dec.funct = ALU_AND;
          FN_OR:   dec.funct = ALU_OR;
          FN_XOR:  dec.funct = ALU_XOR;
          FN_NOR:  dec.funct = ALU_NOR;
          FN_SLT:  dec.funct = ALU_SLT;
          // Shifts operate on rt; the amount comes from shamt or rs[4:0]
          FN_SLL:  begin dec.funct = ALU_SLL; dec.data1 = rt_data; dec.data2 = {27'b0, shamt}; end
          FN_SRA:  begin dec.funct = ALU_SRA; dec.data1 = rt_data; dec.data2 = {27'b0, shamt}; end
          FN_SLLV: begin dec.funct = ALU_SLL; dec.data1 = rt_data; dec.data2 = {27'b0, rs_data[4:0]}; end
          FN_SRAV: begin dec.funct = ALU_SRA; dec.data1 = rt_data; dec.data2 = {27'b0, rs_data[4:0]}; end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_MUL: begin
        if (funct == FN_MUL) dec.funct = ALU_MUL;
        else                 dec.illegal = 1'b1;
      end
      OP_ADDI:  begin dec.funct = ALU_ADD; dec.data2 = imm_sx; dec.trap_cap = 1'b1; end
      OP_ADDIU: begin dec.funct = ALU_ADD; dec.data2 = imm_sx; end
      OP_SLTI:  begin dec.funct = ALU_SLT; dec.data2 = imm_sx; end
      OP_ANDI:  begin dec.funct = ALU_AND; dec.data2 = imm_zx; end
      OP_ORI:   begin dec.funct = ALU_OR;  dec.data2 = imm_zx; end
      OP_XORI:  begin dec.funct = ALU_XOR; dec.data2 = imm_zx; end
      // lui is realised as imm << 16 on the shifter
      OP_LUI:   begin dec.funct = ALU_SLL; dec.data1 = imm_zx; dec.data2 = 32'd16; end
      default:  dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequential requester for the 32-bit ALU: decode, drive operands, wait
// ALU_LATENCY cycles, hold response. Optional counters under ALU_ISSUE_STATS_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int ALU_LATENCY = 1,
  parameter bit TRAP_ON_OVF = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [5:0]  i_opcode,
  input  logic [5:0]  i_funct,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  input  logic [15:0] i_imm,
  input  logic [4:0]  i_shamt,
  output logic [31:0] o_alu_data1,
  output logic [31:0] o_alu_data2,
  output logic [4:0]  o_alu_shamt,
  output logic [4:0]  o_alu_funct,
  input  logic [31:0] i_alu_result,
  input  logic        i_alu_zero,
  input  logic        i_alu_overflow,
  input  logic        i_alu_carry,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_result,
  output logic        o_rsp_nonzero,
  output logic        o_rsp_carry,
  output logic        o_rsp_trap,
  output logic        o_rsp_illegal
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0] o_stat_ops,
  output logic [15:0] o_stat_traps
`endif
);

  localparam logic [3:0] LAT = 4'(ALU_LATENCY);

  state_t     state, state_nxt;
  dec_t       dec;
  logic [3:0] cnt;
  logic       trap_cap_q;
  logic       ovf_trap;

  alu_op_decode u_dec (
    .opcode  (i_opcode),
    .funct   (i_funct),
    .rs_data (i_rs_data),
    .rt_data (i_rt_data),
    .imm     (i_imm),
    .shamt   (i_shamt),
    .dec     (dec)
  );

  assign o_req_ready = (state == ST_IDLE);
  assign o_rsp_valid = (state == ST_RESP);
  assign ovf_trap    = trap_cap_q & i_alu_overflow & TRAP_ON_OVF;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (i_req_valid) state_nxt = dec.illegal ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == 4'd1) state_nxt = ST_RESP;
      ST_RESP: if (i_rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_alu_data1   <= '0;
      o_alu_data2   <= '0;
      o_alu_shamt   <= '0;
      o_alu_funct   <= '0;
      o_rsp_result  <= '0;
      o_rsp_nonzero <= 1'b0;
      o_rsp_carry   <= 1'b0;
      o_rsp_trap    <= 1'b0;
      o_rsp_illegal <= 1'b0;
      cnt           <= '0;
      trap_cap_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (i_req_valid) begin
          // Illegal ops bypass the ALU and leave its operands untouched
          if (dec.illegal) begin
            o_rsp_result  <= '0;
            o_rsp_nonzero <= 1'b0;
            o_rsp_carry   <= 1'b0;
            o_rsp_trap    <= 1'b0;
            o_rsp_illegal <= 1'b1;
          end else begin
            o_alu_data1 <= dec.data1;
            o_alu_data2 <= dec.data2;
            o_alu_shamt <= i_shamt;
            o_alu_funct <= dec.funct;
            cnt         <= LAT;
            trap_cap_q  <= dec.trap_cap;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            o_rsp_result  <= ovf_trap ? 32'd0 : i_alu_result;
            o_rsp_nonzero <= i_alu_zero;
            o_rsp_carry   <= i_alu_carry;
            o_rsp_trap    <= ovf_trap;
            o_rsp_illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stat_ops   <= '0;
      o_stat_traps <= '0;
    end else if (o_rsp_valid && i_rsp_ready) begin
      o_stat_ops <= o_stat_ops + 32'd1;
      if (o_rsp_trap && o_stat_traps != 16'hFFFF) o_stat_traps <= o_stat_traps + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: two instances (latency 1 and 3) driven
// by a behavioural ALU; directed vectors push expected responses to queues.
module tb_alu_issue_ctrl;

  typedef struct packed {
    logic [31:0] r;
    logic        ovf;
    logic        c;
  } alu_out_t;

  typedef struct packed {
    logic [31:0] result;
    logic        nz;
    logic        c;
    logic        t;
    logic        il;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [5:0]  opcode, funct;
  logic [31:0] rs, rt;
  logic [15:0] imm;
  logic [4:0]  shamt;
  logic        req_valid1, req_valid3, rsp_ready1, rsp_ready3;

  logic        req_ready1, rsp_valid1, rsp_nz1, rsp_c1, rsp_t1, rsp_il1;
  logic [31:0] alu_d1_1, alu_d2_1, rsp_res1;
  logic [4:0]  alu_sh1, alu_f1;
  logic        req_ready3, rsp_valid3, rsp_nz3, rsp_c3, rsp_t3, rsp_il3;
  logic [31:0] alu_d1_3, alu_d2_3, rsp_res3;
  logic [4:0]  alu_sh3, alu_f3;

  int checks = 0;
  int fails  = 0;
  rsp_t q1[$];
  rsp_t q3[$];
  rsp_t e1, e3;
  logic [4:0]  prev_f, prev_sh;
  logic [31:0] prev_d1, prev_d2;

  function automatic alu_out_t alu_model(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    alu_out_t o;
    logic [32:0] s;
    o = '0;
    s = '0;
    case (f)
      5'b00000: o.r = a & b;
      5'b00001: o.r = a | b;
      5'b00010: begin
        s = {1'b0, a} + {1'b0, b};
        o.r = s[31:0]; o.c = s[32];
        o.ovf = (a[31] == b[31]) && (s[31] != a[31]);
      end
      5'b00011: o.r = ~(a | b);
      5'b00100: o.r = a * b;
      5'b00101: o.r = a << b[4:0];
      5'b00110: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        o.r = s[31:0]; o.c = s[32];
        o.ovf = (a[31] != b[31]) && (s[31] != a[31]);
      end
      5'b00111: o.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'b01000: o.r = $signed(a) >>> b[4:0];
      5'b01011: o.r = a ^ b;
      default:  o.r = '0;
    endcase
    return o;
  endfunction

  function automatic rsp_t mk(input logic [31:0] r, input logic nz, input logic c, input logic t, input logic il);
    rsp_t x;
    x.result = r; x.nz = nz; x.c = c; x.t = t; x.il = il;
    return x;
  endfunction

  alu_out_t m1, m3;
  assign m1 = alu_model(alu_f1, alu_d1_1, alu_d2_1);
  assign m3 = alu_model(alu_f3, alu_d1_3, alu_d2_3);

  alu_issue_ctrl #(.ALU_LATENCY(1), .TRAP_ON_OVF(1'b1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid1), .o_req_ready(req_ready1),
    .i_opcode(opcode), .i_funct(funct), .i_rs_data(rs), .i_rt_data(rt), .i_imm(imm), .i_shamt(shamt),
    .o_alu_data1(alu_d1_1), .o_alu_data2(alu_d2_1), .o_alu_shamt(alu_sh1), .o_alu_funct(alu_f1),
    .i_alu_result(m1.r), .i_alu_zero(m1.r != 32'd0), .i_alu_overflow(m1.ovf), .i_alu_carry(m1.c),
    .o_rsp_valid(rsp_valid1), .i_rsp_ready(rsp_ready1), .o_rsp_result(rsp_res1),
    .o_rsp_nonzero(rsp_nz1), .o_rsp_carry(rsp_c1), .o_rsp_trap(rsp_t1), .o_rsp_illegal(rsp_il1)
  );

  alu_issue_ctrl #(.ALU_LATENCY(3), .TRAP_ON_OVF(1'b1)) dut3 (
    .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid3), .o_req_ready(req_ready3),
    .i_opcode(opcode), .i_funct(funct), .i_rs_data(rs), .i_rt_data(rt), .i_imm(imm), .i_shamt(shamt),
    .o_alu_data1(alu_d1_3), .o_alu_data2(alu_d2_3), .o_alu_shamt(alu_sh3), .o_alu_funct(alu_f3),
    .i_alu_result(m3.r), .i_alu_zero(m3.r != 32'd0), .i_alu_overflow(m3.ovf), .i_alu_carry(m3.c),
    .o_rsp_valid(rsp_valid3), .i_rsp_ready(rsp_ready3), .o_rsp_result(rsp_res3),
    .o_rsp_nonzero(rsp_nz3), .o_rsp_carry(rsp_c3), .o_rsp_trap(rsp_t3), .o_rsp_illegal(rsp_il3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Response monitors: compare whenever a response handshake is presented
  always @(negedge clk) begin
    if (!rst && rsp_valid1 && rsp_ready1) begin
      if (q1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("rsp1_result",  rsp_res1, e1.result);
        chk("rsp1_nonzero", {31'b0, rsp_nz1}, {31'b0, e1.nz});
        chk("rsp1_carry",   {31'b0, rsp_c1},  {31'b0, e1.c});
        chk("rsp1_trap",    {31'b0, rsp_t1},  {31'b0, e1.t});
        chk("rsp1_illegal", {31'b0, rsp_il1}, {31'b0, e1.il});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rsp_valid3 && rsp_ready3) begin
      if (q3.size() == 0) chk("rsp3_unexpected", 32'd1, 32'd0);
      else begin
        e3 = q3.pop_front();
        chk("rsp3_result",  rsp_res3, e3.result);
        chk("rsp3_nonzero", {31'b0, rsp_nz3}, {31'b0, e3.nz});
        chk("rsp3_carry",   {31'b0, rsp_c3},  {31'b0, e3.c});
        chk("rsp3_trap",    {31'b0, rsp_t3},  {31'b0, e3.t});
        chk("rsp3_illegal", {31'b0, rsp_il3}, {31'b0, e3.il});
      end
    end
  end

  task automatic issue1(input string nm, input logic [5:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b, input logic [15:0] im,
                        input logic [4:0] sh, input bit legal, input logic [4:0] ef,
                        input logic [31:0] ed1, input logic [31:0] ed2, input rsp_t er);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready1 && n < 50) begin @(negedge clk); n++; end
    if (!req_ready1) begin
      chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    opcode = op; funct = fn; rs = a; rt = b; imm = im; shamt = sh;
    req_valid1 = 1'b1;
    q1.push_back(er);
    @(posedge clk);
    #1 req_valid1 = 1'b0;
    if (legal) begin
      prev_f = ef; prev_d1 = ed1; prev_d2 = ed2; prev_sh = sh;
    end
    chk({nm, "_alu_funct"}, {27'b0, alu_f1}, {27'b0, prev_f});
    chk({nm, "_alu_data1"}, alu_d1_1, prev_d1);
    chk({nm, "_alu_data2"}, alu_d2_1, prev_d2);
    chk({nm, "_alu_shamt"}, {27'b0, alu_sh1}, {27'b0, prev_sh});
    n = 0;
    while (!rsp_valid1 && n < 20) begin @(posedge clk); #1; n++; end
    chk({nm, "_latency"}, n, legal ? 32'd1 : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    rst = 1'b1;
    opcode = '0; funct = '0; rs = '0; rt = '0; imm = '0; shamt = '0;
    req_valid1 = 1'b0; req_valid3 = 1'b0; rsp_ready1 = 1'b1; rsp_ready3 = 1'b0;
    prev_f = '0; prev_d1 = '0; prev_d2 = '0; prev_sh = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", {31'b0, req_ready1}, 32'd1);
    chk("reset_rsp_valid", {31'b0, rsp_valid1}, 32'd0);
    chk("reset_alu_funct", {27'b0, alu_f1}, 32'd0);
    chk("reset_alu_data1", alu_d1_1, 32'd0);
    chk("reset_rsp_result", rsp_res1, 32'd0);
    rst = 1'b0;

    issue1("add_ovf",  6'h00, 6'h20, 32'h7FFFFFFF, 32'h1, 16'h0, 5'd0, 1'b1, 5'b00010, 32'h7FFFFFFF, 32'h1, mk(32'h0, 1'b1, 1'b0, 1'b1, 1'b0));
    issue1("addu",     6'h00, 6'h21, 32'h7FFFFFFF, 32'h1, 16'h0, 5'd0, 1'b1, 5'b00010, 32'h7FFFFFFF, 32'h1, mk(32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0));
    issue1("sll",      6'h00, 6'h00, 32'h0, 32'h3, 16'h0, 5'd4, 1'b1, 5'b00101, 32'h3, 32'h4, mk(32'h30, 1'b1, 1'b0, 1'b0, 1'b0));
    issue1("lui",      6'h0F, 6'h00, 32'h0, 32'h0, 16'h1234, 5'd0, 1'b1, 5'b00101, 32'h1234, 32'd16, mk(32'h12340000, 1'b1, 1'b0, 1'b0, 1'b0));
    issue1("illegal",  6'h3F, 6'h00, 32'h55, 32'h66, 16'hFFFF, 5'd9, 1'b0, 5'b0, 32'h0, 32'h0, mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    issue1("sub_eq",   6'h00, 6'h22, 32'h5, 32'h5, 16'h0, 5'd0, 1'b1, 5'b00110, 32'h5, 32'h5, mk(32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    issue1("addi_ovf", 6'h08, 6'h00, 32'h7FFFFFFF, 32'h0, 16'h0001, 5'd0, 1'b1, 5'b00010, 32'h7FFFFFFF, 32'h1, mk(32'h0, 1'b1, 1'b0, 1'b1, 1'b0));
    issue1("addiu_sx", 6'h09, 6'h00, 32'h1, 32'h0, 16'hFFFF, 5'd0, 1'b1, 5'b00010, 32'h1, 32'hFFFFFFFF, mk(32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    issue1("andi_zx",  6'h0C, 6'h00, 32'hFFFFFFFF, 32'h0, 16'h8001, 5'd0, 1'b1, 5'b00000, 32'hFFFFFFFF, 32'h8001, mk(32'h8001, 1'b1, 1'b0, 1'b0, 1'b0));
    issue1("sllv",     6'h00, 6'h04, 32'h23, 32'h1, 16'h0, 5'd0, 1'b1, 5'b00101, 32'h1, 32'h3, mk(32'h8, 1'b1, 1'b0, 1'b0, 1'b0));
    issue1("slt_neg",  6'h00, 6'h2A, 32'hFFFFFFFF, 32'h1, 16'h0, 5'd0, 1'b1, 5'b00111, 32'hFFFFFFFF, 32'h1, mk(32'h1, 1'b1, 1'b0, 1'b0, 1'b0));
    issue1("sra",      6'h00, 6'h03, 32'h0, 32'h80000000, 16'h0, 5'd4, 1'b1, 5'b01000, 32'h80000000, 32'h4, mk(32'hF8000000, 1'b1, 1'b0, 1'b0, 1'b0));

    // Latency 3 with backpressure on the response
    @(negedge clk);
    opcode = 6'h00; funct = 6'h24; rs = 32'h0000F0F0; rt = 32'h0000FF00; imm = '0; shamt = '0;
    req_valid3 = 1'b1;
    q3.push_back(mk(32'h0000F000, 1'b1, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1 req_valid3 = 1'b0;
    chk("lat3_alu_funct", {27'b0, alu_f3}, 32'd0);
    chk("lat3_alu_data1", alu_d1_3, 32'h0000F0F0);
    n = 0;
    while (!rsp_valid3 && n < 20) begin @(posedge clk); #1; n++; end
    chk("lat3_latency", n, 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("lat3_hold_valid", {31'b0, rsp_valid3}, 32'd1);
      chk("lat3_hold_result", rsp_res3, 32'h0000F000);
      chk("lat3_hold_ready", {31'b0, req_ready3}, 32'd0);
      @(posedge clk);
      #1;
    end
    rsp_ready3 = 1'b1;
    @(posedge clk);
    #1;
    chk("lat3_ready_after", {31'b0, req_ready3}, 32'd1);
    chk("lat3_valid_after", {31'b0, rsp_valid3}, 32'd0);

    // Reset while the request is in WAIT
    @(negedge clk);
    opcode = 6'h00; funct = 6'h25; rs = 32'h12; rt = 32'h21;
    req_valid3 = 1'b1;
    @(posedge clk);
    #1 req_valid3 = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_wait", {31'b0, req_ready3}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", {31'b0, req_ready3}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid3}, 32'd0);
    chk("rst_alu_data1", alu_d1_3, 32'd0);
    chk("rst_alu_data2", alu_d2_3, 32'd0);
    chk("rst_alu_funct", {27'b0, alu_f3}, 32'd0);
    chk("rst_rsp_result", rsp_res3, 32'd0);
    chk("rst_rsp_nonzero", {31'b0, rsp_nz3}, 32'd0);
    chk("rst_rsp_illegal1", {31'b0, rsp_il1}, 32'd0);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (rsp_valid3) seen = 1'b1;
    end
    chk("rst_no_response", {31'b0, seen}, 32'd0);

    repeat (2) @(posedge clk);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q3_drained", q3.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential requester for the 32-bit ALU in the single-cycle datapath.
- Accepts a decoded-instruction request (opcode, funct, register operands, immediate, shamt) over a valid/ready handshake and maps it to the 5-bit ALU function code.
- Drives registered operands into the ALU, waits a fixed latency, then captures result and flags into a response register held until the consumer takes it.
- Adds MIPS overflow-trap and illegal-op reporting, which the ALU itself does not provide.

Parameters:
- ALU_LATENCY, 1, cycles from operands driven to ALU outputs sampled (1..15; 1 = combinational ALU).
- TRAP_ON_OVF, 1, 1: signed add/sub/addi overflow sets trap and forces result 0; 0: overflow is reported only.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  high only in IDLE
- i_opcode  in  6  instruction opcode
- i_funct  in  6  R-type funct
- i_rs_data  in  32  rs value
- i_rt_data  in  32  rt value
- i_imm  in  16  immediate
- i_shamt  in  5  shift amount
- o_alu_data1  out  32  ALU operand 1 (registered)
- o_alu_data2  out  32  ALU operand 2 (registered)
- o_alu_shamt  out  5  ALU shamt (registered)
- o_alu_funct  out  5  ALU function code (registered)
- i_alu_result  in  32  ALU result
- i_alu_zero  in  1  ALU zero flag; high when the result is NON-zero
- i_alu_overflow  in  1  ALU overflow
- i_alu_carry  in  1  ALU carry
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response accepted
- o_rsp_result  out  32  captured result
- o_rsp_nonzero  out  1  captured i_alu_zero
- o_rsp_carry  out  1  captured carry
- o_rsp_trap  out  1  signed-overflow trap
- o_rsp_illegal  out  1  unsupported opcode/funct

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous, active-high on i_reset.
- Reset values: state IDLE; all o_alu_* = 0; all o_rsp_* = 0.
- Reset mid-operation: the in-flight request is discarded and no response is issued.

FSM: IDLE -> WAIT -> RESP -> IDLE.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid, decode and register the o_alu_* values, then load the latency counter with ALU_LATENCY.
  - Illegal op: go straight to RESP with result=0, illegal=1, trap=0, carry=0, nonzero=0. The o_alu_* outputs are not updated.
- WAIT:
  - Decrement the counter each cycle.
  - At the edge where the counter reaches 0, capture the ALU outputs into o_rsp_*, then go to RESP.
  - Timing: accept at cycle T -> o_alu_* valid at T+1 -> o_rsp_valid from T+ALU_LATENCY+1.
- RESP:
  - o_rsp_valid=1; o_rsp_* held stable until i_rsp_ready.
  - On i_rsp_ready: drop o_rsp_valid and return to IDLE. Ready is high the following cycle; no same-cycle re-accept.
- o_alu_* hold their values until the next legal accept.

Decode (ALU codes: and 00000, or 00001, add 00010, nor 00011, mul 00100, sll 00101, sub 00110, slt 00111, sra 01000, xor 01011).
- R-type (op 0x00):
  - add 0x20 and sub 0x22: trap-capable.
  - addu 0x21, subu 0x23, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A: data1=rs, data2=rt.
  - sll 0x00 and sra 0x03: data1=rt, data2={27'b0, shamt}.
  - sllv 0x04 and srav 0x07: data1=rt, data2={27'b0, rs[4:0]}.
- mul: op 0x1C, funct 0x02.
- I-type (data1=rs):
  - Sign-extended immediate: addi 0x08 (trap-capable), addiu 0x09, slti 0x0A.
  - Zero-extended immediate: andi 0x0C, ori 0x0D, xori 0x0E.
  - lui 0x0F: sll with data1={16'b0, imm}, data2=16.
- o_alu_shamt always carries i_shamt.
- Trap: asserted only for trap-capable ops when i_alu_overflow=1 and TRAP_ON_OVF=1. Carry is captured regardless of trap.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- When defined, adds outputs o_stat_ops[31:0] and o_stat_traps[15:0]:
  - o_stat_ops increments on each response handshake and wraps.
  - o_stat_traps increments on each trap response and saturates at 0xFFFF.
  - Both clear on reset.
- When undefined, neither the ports nor the logic exist.

Decomposition:
- Package alu_pkg holds:
  - ALU function-code localparams;
  - opcode and funct constants;
  - the FSM state encoding.
- Sub-module alu_op_decode: purely combinational. Maps opcode/funct/operands to {funct code, data1, data2, trap_capable, illegal}.

Test Plan:
- add rs=0x7FFFFFFF rt=1, ALU_LATENCY=1 -> o_alu_funct=00010; rsp_valid 2 cycles after accept; trap=1, result=0.
- addu with the same operands -> trap=0, result=0x80000000, nonzero=1.
- sll rt=0x00000003 shamt=4 -> data1=3, data2=4, result=0x30. lui imm=0x1234 -> result=0x12340000.
- op 0x3F -> illegal=1, rsp_valid the cycle after accept, o_alu_* unchanged.
- ALU_LATENCY=3, i_rsp_ready held low 5 cycles -> rsp_valid at T+4; outputs stable; ready low throughout.
- Reset asserted in WAIT -> no response; next cycle ready=1 and all outputs 0.
